// File: rtl/pixel_fb_pkg.sv
// Shared types and frame-buffer geometry for the pixel frame-buffer writer.
package pixel_fb_pkg;

  localparam int unsigned FB_W       = 320;
  localparam int unsigned FB_H       = 180;
  localparam int unsigned FB_PIXELS  = FB_W * FB_H;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned FIFO_DEPTH = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    rgb12_t            rgb;
  } fb_wr_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of frame-buffer write entries with synchronous flush.
// Read data is the head entry, valid whenever empty_c is low.
module pixel_fifo
  import pixel_fb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  fb_wr_t wr_data,
  input  logic   pop,
  output fb_wr_t rd_data_c,
  output logic   full_c,
  output logic   empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  fb_wr_t       mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Status flags; a pop frees the slot so a push on a full FIFO still lands.
  always_comb begin
    empty_c   = (wr_ptr == rd_ptr);
    full_c    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    wr_en     = push && (!full_c || pop);
    rd_en     = pop && !empty_c;
    rd_data_c = mem[rd_ptr[PW-1:0]];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Bounds-checks and linearises a non-stallable pixel stream, buffers the
// writes, and drives a double-banked frame buffer over a valid/ready port.
module pixel_fb_writer #(
  parameter int unsigned FB_W       = pixel_fb_pkg::FB_W,
  parameter int unsigned FB_H       = pixel_fb_pkg::FB_H,
  parameter int unsigned FIFO_DEPTH = pixel_fb_pkg::FIFO_DEPTH,
  parameter int unsigned ADDR_W     = pixel_fb_pkg::ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [3:0]        r_in,
  input  logic [3:0]        g_in,
  input  logic [3:0]        b_in,
  input  logic              valid_in,
  input  logic              clear_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [11:0]       mem_data_out,
  output logic              mem_we_out,
  input  logic              mem_ready_in,
  output logic              bank_out,
  output logic              frame_done_out,
  output logic              overflow_out,
  output logic [15:0]       drop_count_out
);

  import pixel_fb_pkg::*;

  localparam int unsigned PIX   = FB_W * FB_H;
  localparam int unsigned CNT_W = $clog2(PIX);
  localparam int unsigned EA_W  = $bits(fb_wr_t) - $bits(rgb12_t);
  localparam logic [10:0] X_LIM = 11'(FB_W);
  localparam logic [9:0]  Y_LIM = 10'(FB_H);

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic             in_bounds_c;
  logic             s1_valid;
  logic [10:0]      s1_x;
  logic [9:0]       s1_y;
  rgb12_t           s1_rgb;
  logic [EA_W-1:0]  lin_addr_c;
  logic             s2_valid;
  fb_wr_t           s2_entry;
  fb_wr_t           fifo_rd_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic             push_c;
  logic             pop_c;
  logic             hs_c;
  logic             wrap_c;
  logic             bank_nxt_c;
  logic [CNT_W-1:0] frame_cnt;
  wr_state_t        state;
  wr_state_t        state_nxt;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_bounds_c = (x_in < X_LIM) && (y_in < Y_LIM);
  assign lin_addr_c  = EA_W'(s1_y) * EA_W'(FB_W) + EA_W'(s1_x);
  assign push_c      = s2_valid && !clear_in;

  // Input register plus saturating out-of-bounds drop counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_x           <= '0;
      s1_y           <= '0;
      s1_rgb         <= '0;
      drop_count_out <= '0;
    end else begin
      s1_valid <= valid_in && in_bounds_c && !clear_in;
      s1_x     <= x_in;
      s1_y     <= y_in;
      s1_rgb   <= '{r: r_in, g: g_in, b: b_in};
      if (clear_in)
        drop_count_out <= '0;
      else if (valid_in && !in_bounds_c && (drop_count_out != 16'hFFFF))
        drop_count_out <= drop_count_out + 16'd1;
    end
  end

  // Address stage: linear address computed from the captured coordinate.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_valid       <= s1_valid && !clear_in;
      s2_entry.addr  <= lin_addr_c;
      s2_entry.rgb   <= s1_rgb;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n),
    .flush     (clear_in),
    .push      (push_c),
    .wr_data   (s2_entry),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Output FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, FIFO pop and handshake decode; clear abandons any write.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    hs_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c     = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready_in) begin
          hs_c = 1'b1;
          if (!fifo_empty_c) pop_c = 1'b1;
          else               state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear_in) begin
      state_nxt = S_IDLE;
      pop_c     = 1'b0;
      hs_c      = 1'b0;
    end
  end

  assign wrap_c     = hs_c && (frame_cnt == CNT_W'(PIX - 1));
  assign bank_nxt_c = bank_out ^ wrap_c;

  // Frame counter, bank select, swap pulse and sticky overflow flag.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt      <= '0;
      bank_out       <= 1'b0;
      frame_done_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else if (clear_in) begin
      frame_cnt      <= '0;
      bank_out       <= 1'b0;
      frame_done_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      frame_done_out <= wrap_c;
      bank_out       <= bank_nxt_c;
      if (hs_c) frame_cnt <= wrap_c ? '0 : frame_cnt + CNT_W'(1);
      if (s2_valid && fifo_full_c && !pop_c) overflow_out <= 1'b1;
    end
  end

  // Output holding register; bank offset applied as the entry is issued.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
    end else begin
      mem_we_out <= (state_nxt == S_WRITE);
      if (pop_c) begin
        mem_addr_out <= bank_nxt_c ? ADDR_W'(PIX) + ADDR_W'(fifo_rd_c.addr)
                                   : ADDR_W'(fifo_rd_c.addr);
        mem_data_out <= fifo_rd_c.rgb;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: vector table plus multi-cycle sequences.
module tb_pixel_fb_writer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [3:0]  r_in, g_in, b_in;
  logic        valid_in;
  logic        clear_in;
  logic [16:0] mem_addr_out;
  logic [11:0] mem_data_out;
  logic        mem_we_out;
  logic        mem_ready_in;
  logic        bank_out;
  logic        frame_done_out;
  logic        overflow_out;
  logic [15:0] drop_count_out;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  logic [28:0] wr_log [$];

  logic        prev_we = 1'b0;
  logic        prev_rdy = 1'b1;
  logic [16:0] prev_addr;
  logic [11:0] prev_data;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        exp_wr;
    logic [16:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  pixel_fb_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .x_in           (x_in),
    .y_in           (y_in),
    .r_in           (r_in),
    .g_in           (g_in),
    .b_in           (b_in),
    .valid_in       (valid_in),
    .clear_in       (clear_in),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_we_out     (mem_we_out),
    .mem_ready_in   (mem_ready_in),
    .bank_out       (bank_out),
    .frame_done_out (frame_done_out),
    .overflow_out   (overflow_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pix(input logic [10:0] x, input logic [9:0] y, input logic [11:0] rgb);
    x_in = x;
    y_in = y;
    {r_in, g_in, b_in} = rgb;
    valid_in = 1'b1;
  endtask

  // Handshake log, swap-pulse counter and stall-stability checks.
  always @(negedge clk_in) begin
    if (mem_we_out && mem_ready_in) wr_log.push_back({mem_addr_out, mem_data_out});
    if (frame_done_out) done_pulses++;
    if (prev_we && !prev_rdy && mem_we_out && rst_in) begin
      check("stall_addr", 32'(mem_addr_out), 32'(prev_addr));
      check("stall_data", 32'(mem_data_out), 32'(prev_data));
    end
    prev_we   = mem_we_out;
    prev_rdy  = mem_ready_in;
    prev_addr = mem_addr_out;
    prev_data = mem_data_out;
  end

  initial begin
    vecs[0] = '{11'd100,  10'd50,   12'hF0A, 1'b1, 17'd16100};
    vecs[1] = '{11'd320,  10'd0,    12'h111, 1'b0, 17'd0};
    vecs[2] = '{11'd0,    10'd180,  12'h222, 1'b0, 17'd0};
    vecs[3] = '{11'd319,  10'd179,  12'h5A3, 1'b1, 17'd57599};
    vecs[4] = '{11'd0,    10'd0,    12'h123, 1'b1, 17'd0};
    vecs[5] = '{11'd2047, 10'd1023, 12'hFFF, 1'b0, 17'd0};
    vecs[6] = '{11'd5,    10'd1,    12'h0C7, 1'b1, 17'd325};

    rst_in = 1'b1;
    x_in = '0; y_in = '0; r_in = '0; g_in = '0; b_in = '0;
    valid_in = 1'b0; clear_in = 1'b0; mem_ready_in = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    check("rst_we",    32'(mem_we_out), 0);
    check("rst_addr",  32'(mem_addr_out), 0);
    check("rst_data",  32'(mem_data_out), 0);
    check("rst_bank",  32'(bank_out), 0);
    check("rst_done",  32'(frame_done_out), 0);
    check("rst_ovf",   32'(overflow_out), 0);
    check("rst_drop",  32'(drop_count_out), 0);
    repeat (3) step();
    rst_in = 1'b1;
    repeat (5) step();

    // Single pixels: exact latency, address, data and drops.
    foreach (vecs[i]) begin
      set_pix(vecs[i].x, vecs[i].y, vecs[i].rgb);
      step();
      valid_in = 1'b0;
      if (vecs[i].exp_wr) begin
        step(); step();
        check("lat_early", 32'(mem_we_out), 0);
        step();
        check("lat_we",   32'(mem_we_out), 1);
        check("vec_addr", 32'(mem_addr_out), 32'(vecs[i].exp_addr));
        check("vec_data", 32'(mem_data_out), 32'(vecs[i].rgb));
        step(); step();
      end else begin
        repeat (5) step();
        check("drop_no_we", 32'(mem_we_out), 0);
      end
    end
    check("drop_count", 32'(drop_count_out), 3);
    check("no_ovf", 32'(overflow_out), 0);
    check("vec_writes", 32'(wr_log.size()), 4);

    // Back-pressure: 20 pixels into a stalled port, 17 survive.
    wr_log.delete();
    mem_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_pix(11'(i), 10'd2, 12'(12'h100 + i));
      step();
    end
    valid_in = 1'b0;
    repeat (8) step();
    check("bp_ovf",  32'(overflow_out), 1);
    check("bp_we",   32'(mem_we_out), 1);
    check("bp_addr", 32'(mem_addr_out), 640);
    check("bp_data", 32'(mem_data_out), 32'h100);
    mem_ready_in = 1'b1;
    for (int i = 0; i < 60 && wr_log.size() < 17; i++) step();
    repeat (5) step();
    check("bp_count", 32'(wr_log.size()), 17);
    for (int i = 0; i < 17 && i < wr_log.size(); i++) begin
      check("bp_order_addr", 32'(wr_log[i][28:12]), 32'(640 + i));
      check("bp_order_data", 32'(wr_log[i][11:0]), 32'(12'h100 + i));
    end
    check("bp_idle", 32'(mem_we_out), 0);

    // Clear, then a full frame to force a bank swap.
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    check("clr_ovf",  32'(overflow_out), 0);
    check("clr_drop", 32'(drop_count_out), 0);
    wr_log.delete();
    done_pulses = 0;
    for (int y = 0; y < 180; y++) begin
      for (int x = 0; x < 320; x++) begin
        set_pix(11'(x), 10'(y), 12'(x));
        step();
      end
    end
    valid_in = 1'b0;
    repeat (10) step();
    check("frame_writes", 32'(wr_log.size()), 57600);
    check("frame_pulses", 32'(done_pulses), 1);
    check("frame_bank",   32'(bank_out), 1);
    if (wr_log.size() > 0) begin
      check("frame_first", 32'(wr_log[0][28:12]), 0);
      check("frame_last",  32'(wr_log[wr_log.size()-1][28:12]), 57599);
    end
    wr_log.delete();
    set_pix(11'd100, 10'd50, 12'hF0A);
    step();
    valid_in = 1'b0;
    repeat (6) step();
    check("bank1_count", 32'(wr_log.size()), 1);
    if (wr_log.size() > 0) check("bank1_addr", 32'(wr_log[0][28:12]), 73700);

    // Clear during a stalled write with five entries queued.
    mem_ready_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) set_pix(11'd400, 10'd4, 12'h333);
      else        set_pix(11'(i), 10'd4, 12'(12'h200 + i));
      step();
    end
    valid_in = 1'b0;
    repeat (6) step();
    check("pre_clr_we",   32'(mem_we_out), 1);
    check("pre_clr_drop", 32'(drop_count_out), 1);
    set_pix(11'd1, 10'd1, 12'h777);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    valid_in = 1'b0;
    check("clr_we",   32'(mem_we_out), 0);
    check("clr_bank", 32'(bank_out), 0);
    check("clr_done", 32'(frame_done_out), 0);
    check("clr_drop2", 32'(drop_count_out), 0);
    check("clr_ovf2", 32'(overflow_out), 0);
    wr_log.delete();
    mem_ready_in = 1'b1;
    repeat (12) step();
    check("clr_no_writes", 32'(wr_log.size()), 0);
    check("clr_idle", 32'(mem_we_out), 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) begin
      if (i == 1) set_pix(11'd999, 10'd3, 12'h444);
      else        set_pix(11'(i), 10'd3, 12'(12'h300 + i));
      step();
    end
    check("burst_we", 32'(mem_we_out), 1);
    #2 rst_in = 1'b0;
    wr_log.delete();
    #1;
    check("arst_we",   32'(mem_we_out), 0);
    check("arst_addr", 32'(mem_addr_out), 0);
    check("arst_data", 32'(mem_data_out), 0);
    check("arst_bank", 32'(bank_out), 0);
    check("arst_done", 32'(frame_done_out), 0);
    check("arst_ovf",  32'(overflow_out), 0);
    check("arst_drop", 32'(drop_count_out), 0);
    valid_in = 1'b0;
    step();
    rst_in = 1'b1;
    repeat (8) step();
    check("arst_no_writes", 32'(wr_log.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
